// File: rtl/pool_rows.sv
// Vertical pooling stage: reduces each window of K rows per lane to one row by
// max or floor-average; transparent combinational bypass when pooling is off.
module pool_rows #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int MASK_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_pool,
  input  logic                           pool_type,
  input  logic [1:0]                     pool_window_size,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           done_pool,
  output logic                           o_dbg_state
);

  localparam int SW = DWIDTH + 2;

  // Handshake: a row is consumed on every rising edge where enable_pool and
  // in_data_available are both high; out_data_available is a one-cycle pulse
  // with out_data valid in that cycle. There is no backpressure.
  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t r_state, w_state_next;

  logic [2:0] r_cnt, w_cnt_next, w_k;
  logic [1:0] r_kshift, w_kshift;
  logic       w_accept, w_first, w_complete;

  logic signed [DWIDTH-1:0] r_max      [MAT_MUL_SIZE];
  logic signed [SW-1:0]     r_sum      [MAT_MUL_SIZE];
  logic signed [DWIDTH-1:0] w_lane     [MAT_MUL_SIZE];
  logic signed [DWIDTH-1:0] w_max_next [MAT_MUL_SIZE];
  logic signed [SW-1:0]     w_sum_next [MAT_MUL_SIZE];
  logic signed [DWIDTH-1:0] w_res      [MAT_MUL_SIZE];

  logic [MAT_MUL_SIZE*DWIDTH-1:0] r_out, w_out_next;
  logic                           r_out_valid;

  always_comb begin
    w_accept = enable_pool & in_data_available;
    w_first  = (r_state == S_IDLE);
    w_kshift = r_kshift;
    // K is taken from the window code only on a window's first row.
    if (w_first) begin
      case (pool_window_size)
        2'd0:    w_kshift = 2'd0;
        2'd1:    w_kshift = 2'd1;
        default: w_kshift = 2'd2;
      endcase
    end
    w_k          = 3'd1 << w_kshift;
    w_cnt_next   = w_first ? 3'd1 : r_cnt + 3'd1;
    w_complete   = w_accept && (w_cnt_next == w_k);
    w_state_next = r_state;
    if (w_accept) w_state_next = w_complete ? S_IDLE : S_ACCUM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_out_next = '0;
    for (int j = 0; j < MAT_MUL_SIZE; j++) begin
      w_lane[j]     = inp_data[j*DWIDTH +: DWIDTH];
      w_max_next[j] = (w_first || (w_lane[j] > r_max[j])) ? w_lane[j] : r_max[j];
      w_sum_next[j] = w_first ? SW'(w_lane[j]) : r_sum[j] + SW'(w_lane[j]);
      // Arithmetic shift floors toward -inf; the quotient always fits DWIDTH.
      w_res[j]      = pool_type ? DWIDTH'(w_sum_next[j] >>> w_kshift) : w_max_next[j];
      w_out_next[j*DWIDTH +: DWIDTH] = validity_mask[j] ? w_res[j] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_kshift    <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      for (int j = 0; j < MAT_MUL_SIZE; j++) begin
        r_max[j] <= '0;
        r_sum[j] <= '0;
      end
    end else if (enable_pool) begin
      r_out_valid <= w_complete;
      if (w_accept) begin
        r_kshift <= w_kshift;
        r_cnt    <= w_complete ? 3'd0 : w_cnt_next;
        for (int j = 0; j < MAT_MUL_SIZE; j++) begin
          r_max[j] <= w_max_next[j];
          r_sum[j] <= w_sum_next[j];
        end
      end
      if (w_complete) r_out <= w_out_next;
    end
  end

  assign out_data           = enable_pool ? r_out : inp_data;
  assign out_data_available = enable_pool ? r_out_valid : in_data_available;
  assign done_pool          = !enable_pool || (r_state == S_IDLE);
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_pool_rows.sv
// Directed bench for pool_rows: expected pooled rows go into a queue and a
// negedge monitor pops and compares them whenever an output pulse appears.
module tb_pool_rows;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable_pool;
  logic         pool_type;
  logic [1:0]   pool_window_size;
  logic         in_data_available;
  logic [W-1:0] inp_data;
  logic [N-1:0] validity_mask;
  logic [W-1:0] out_data;
  logic         out_data_available;
  logic         done_pool;
  logic         o_dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  pool_rows #(.DWIDTH(DW), .MAT_MUL_SIZE(N), .MASK_WIDTH(N)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_pool        (enable_pool),
    .pool_type          (pool_type),
    .pool_window_size   (pool_window_size),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_pool          (done_pool),
    .o_dbg_state        (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lane 1 sits in the low bits.
  function automatic logic [W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = a[7:0]; lb = b[7:0]; lc = c[7:0]; ld = d[7:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic row(input logic [W-1:0] d);
    inp_data          = d;
    in_data_available = 1'b1;
    tick();
    in_data_available = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_valid", W'(out_data_available), W'(0));
    end else if (!enable_pool) begin
      chk("byp_data", out_data, inp_data);
      chk("byp_valid", W'(out_data_available), W'(in_data_available));
      chk("byp_done", W'(done_pool), W'(1));
    end else if (out_data_available) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pulse: got %h expected no output", out_data);
      end else begin
        chk("pool_out", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; enable_pool = 1'b1; pool_type = 1'b0; pool_window_size = 2'd0;
    in_data_available = 1'b0; inp_data = '0; validity_mask = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out_data, '0);
    chk("reset_valid", W'(out_data_available), W'(0));
    chk("reset_done", W'(done_pool), W'(1));
    chk("reset_state", W'(o_dbg_state), W'(0));
    reset = 1'b0;
    tick();

    // Max, K=2
    pool_window_size = 2'd1; pool_type = 1'b0;
    row(pk(3, -5, 7, -128));
    chk("max_done_mid", W'(done_pool), W'(0));
    exp_q.push_back(pk(10, -2, 7, -127));
    row(pk(10, -2, 7, -127));
    chk("max_pulse", W'(out_data_available), W'(1));
    chk("max_done_end", W'(done_pool), W'(1));
    tick();
    chk("max_pulse_len", W'(out_data_available), W'(0));
    chk("max_hold", out_data, pk(10, -2, 7, -127));

    // Average, K=4, including floor of a negative sum
    pool_window_size = 2'd2; pool_type = 1'b1;
    row(pk(5, -1, 127, -128));
    row(pk(6, -1, 127, -128));
    row(pk(7, -1, 127, -128));
    chk("avg_done_mid", W'(done_pool), W'(0));
    exp_q.push_back(pk(4, -2, 127, -128));
    row(pk(-1, -2, 127, -128));
    tick();

    // K=2 with a gap and a window-size change mid-window; next window K=4
    pool_window_size = 2'd1; pool_type = 1'b0;
    row(pk(1, 2, 3, 4));
    pool_window_size = 2'd2;
    repeat (3) tick();
    chk("gap_done", W'(done_pool), W'(0));
    exp_q.push_back(pk(5, 2, 3, 4));
    row(pk(5, -6, 0, 4));
    row(pk(1, 1, 1, 1));
    row(pk(2, 2, 2, 2));
    row(pk(3, 3, 3, 3));
    chk("k4_done_mid", W'(done_pool), W'(0));
    chk("k4_state", W'(o_dbg_state), W'(1));
    exp_q.push_back(pk(3, 3, 3, 3));
    row(pk(0, 0, 0, 0));
    tick();

    // Masking with K=1, back-to-back pulses
    pool_window_size = 2'd0; validity_mask = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pk(9, 0, 9, 0));
      row(pk(9, 9, 9, 9));
    end
    validity_mask = 4'hF;
    tick();

    // Asynchronous reset mid-window discards the partial window
    pool_window_size = 2'd1;
    row(pk(50, 50, 50, 50));
    #3 reset = 1'b1;
    #1;
    chk("arst_done", W'(done_pool), W'(1));
    chk("arst_state", W'(o_dbg_state), W'(0));
    chk("arst_valid", W'(out_data_available), W'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    tick();
    row(pk(1, -1, 1, -1));
    exp_q.push_back(pk(2, -1, 2, -1));
    row(pk(2, -2, 2, -2));
    tick();

    // Bypass: the monitor compares outputs against live inputs
    enable_pool = 1'b0;
    for (int i = 0; i < 8; i++) begin
      inp_data          = pk(i, -i, i * 3, -100);
      in_data_available = (i % 2 == 1);
      tick();
    end
    in_data_available = 1'b0;
    enable_pool       = 1'b1;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_rows.md
Name: pool_rows

Overview:
- Vertical pooling stage that sits directly upstream of the activation block.
- Consumes one row of MAT_MUL_SIZE signed lanes per valid cycle from the normalization stage.
- Reduces each window of K consecutive rows, per lane, to one row by max or average.
- Presents the result with the same data/valid handshake the activation block consumes. With pooling disabled it is a transparent combinational bypass.

Parameters:
- DWIDTH, 8: bits per signed lane.
- MAT_MUL_SIZE, 4: lanes per row.
- MASK_WIDTH, 4: validity mask width; equals MAT_MUL_SIZE.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable_pool  input  1  1 = pool, 0 = bypass.
- pool_type  input  1  0 = max, 1 = average.
- pool_window_size  input  2  window code: 0→K=1, 1→K=2, 2→K=4, 3→K=4 (reserved).
- in_data_available  input  1  inp_data row valid this cycle.
- inp_data  input  MAT_MUL_SIZE*DWIDTH  input row; lane i occupies bits [i*DWIDTH-1 -: DWIDTH], i = 1..MAT_MUL_SIZE.
- validity_mask  input  MASK_WIDTH  bit i-1 = 0 forces output lane i to zero.
- out_data  output  MAT_MUL_SIZE*DWIDTH  pooled row, feeds activation inp_data.
- out_data_available  output  1  one-cycle pulse per pooled row.
- done_pool  output  1  high while no partial window is held.

Behaviour:
- Bypass (enable_pool=0):
  - out_data = inp_data; out_data_available = in_data_available; done_pool = 1.
  - All combinational. Internal state is held frozen, not cleared.
- Reset (async, active-high):
  - FSM to IDLE; row counter, latched K, accumulators, max registers and output register all 0.
  - out_data_available = 0; done_pool = 1 when enabled.
  - Reset asserted mid-window discards the partial window; no output is produced for it.
- FSM states:
  - IDLE: no rows held.
  - ACCUM: 1..K-1 rows of the current window held.
- Accepting a row (enabled, in_data_available=1):
  - In IDLE, the row is the window's first row.
  - K is latched from pool_window_size on that first row. Later changes to pool_window_size are ignored until the next window.
  - First row: max_reg[i] ← lane i; sum[i] ← sign-extended lane i; cnt ← 1.
  - Later rows: max_reg[i] ← signed max(max_reg[i], lane i); sum[i] ← sum[i] + lane i; cnt ← cnt + 1.
- Window completion (the row that makes cnt reach K, including K=1 in IDLE):
  - Next edge loads out_data from the completed window: max → max_reg including this row; average → (sum including this row) >>> log2(K).
  - The shift is arithmetic and floors toward −inf.
  - At the same edge: out_data_available ← 1 for exactly one cycle; FSM → IDLE; cnt ← 0.
  - Latency: 1 cycle after the last row of the window.
- Sum width: DWIDTH+2 bits signed per lane. Cannot overflow for K ≤ 4. The average result always fits DWIDTH.
- Masking: out lane i = 0 if validity_mask[i-1] = 0. The mask is sampled on the completing row.
- Stalls: in_data_available=0 mid-window holds all state; gaps between rows of a window are unlimited.
- Back-to-back windows: a row arriving in the cycle that out_data_available is high starts a new window normally. There are no bubbles; one output per K accepted rows.
- Output holding: out_data holds its last value between pulses. out_data_available is low except on the pulse cycle.
- done_pool (enabled): 1 in IDLE, 0 in ACCUM.
- Toggling enable_pool 0→1 resumes from frozen state. Software clears it via reset before a new layer.

Test Plan:
- Max, K=2, lanes 4, rows [3,-5,7,-128] then [10,-2,7,-127] → one cycle after row 2: out [10,-2,7,-127], pulse 1 cycle, done_pool 0 only between rows.
- Average, K=4, lane1 rows 5,6,7,-1 (sum 17) → 4; lane2 rows -1,-1,-1,-2 (sum -5) → -2 (floor); lane3 127×4 → 127; lane4 -128×4 → -128.
- K=2 with 3-cycle gap between rows and pool_window_size changed to 2 (K=4) mid-window → output after row 2 using K=2; next window uses K=4.
- validity_mask=4'b0101, max K=1, input [9,9,9,9] → out lanes1,3 = 9, lanes2,4 = 0, every cycle a pulse.
- Reset asserted asynchronously (between edges) after 1 of 2 rows, released, then 2 rows [1..] [2..] → no pulse during reset; single output equal to max of the two new rows only.
- enable_pool=0, rows streaming with in_data_available toggling → out_data and out_data_available follow inputs same cycle; done_pool constant 1.
